// File: rtl/vid_timing_ctrl.sv
// vid_timing_ctrl
// Raster scheduler for the TMDS video controller. Walks a horizontal/vertical
// raster, pulls one pixel per active position from an upstream source and drives
// the registered de/hsync/vsync/pixel bundle that feeds the channel encoders.
// A stalled source during active video yields a black pixel and sets a sticky
// underflow flag.
//
// Ports
//   clk         in   pixel clock
//   rst         in   asynchronous, active-low reset
//   en          in   run request, honoured only at frame boundaries
//   pix_in      in   [23:0] upstream pixel {ch2,ch1,ch0}
//   pix_valid   in   pix_in valid
//   pix_ready   out  pixel consumed this cycle (combinational, equals active)
//   frame_start out  1-clk pulse with the first output pixel of a frame
//   de          out  data enable to encoders
//   hsync       out  horizontal sync (HS_POL when asserted)
//   vsync       out  vertical sync (VS_POL when asserted)
//   pix_out     out  [23:0] pixel to encoders, 0 whenever de=0
//   underflow   out  sticky: source not valid while a pixel was needed
//   state_dbg   out  FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: a pixel transfers in a cycle where pix_ready && pix_valid. pix_ready
// depends only on the raster position, never on pix_valid, and there is no
// prefetch: a missing pixel is replaced by black, not waited for.

module vid_timing_ctrl #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        frame_start,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [23:0] pix_out,
    output logic        underflow,
    output logic        state_dbg
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    logic        de_q, de_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        fs_q, fs_d;
    logic        und_q, und_d;
    logic [23:0] pix_q, pix_d;

    logic        run;
    logic        active;

    assign run    = (state_q == S_RUN);
    assign active = run && (h_q < H_ACT) && (v_q < V_ACT);

    // Next state and counters. en only matters in IDLE or on the last clock of
    // a frame, so a mid-frame drop always lets the frame finish.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            S_IDLE: begin
                h_d = '0;
                v_d = '0;
                if (en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    if (v_q == V_LAST) begin
                        v_d     = '0;
                        state_d = en ? S_RUN : S_IDLE;
                    end else begin
                        v_d = v_q + VW'(1);
                    end
                end else begin
                    h_d = h_q + HW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                h_d     = '0;
                v_d     = '0;
            end
        endcase
    end

    // Output bundle, registered one clock behind the counter state.
    always_comb begin
        de_d  = active;
        pix_d = (active && pix_valid) ? pix_in : 24'd0;
        hs_d  = (run && (h_q >= H_SS) && (h_q < H_SE)) ? HS_POL : ~HS_POL;
        vs_d  = (run && (v_q >= V_SS) && (v_q < V_SE)) ? VS_POL : ~VS_POL;
        fs_d  = run && (h_q == '0) && (v_q == '0);
        // A new underflow in the frame_start clock wins over the clear.
        und_d = und_q;
        if (active && !pix_valid) begin
            und_d = 1'b1;
        end else if (fs_d) begin
            und_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            fs_q    <= 1'b0;
            und_q   <= 1'b0;
            pix_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
            und_q   <= und_d;
            pix_q   <= pix_d;
        end
    end

    assign pix_ready   = active;
    assign frame_start = fs_q;
    assign de          = de_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign pix_out     = pix_q;
    assign underflow   = und_q;
    assign state_dbg   = run;

endmodule
